decoder_scan_n: RTL and testbench

//  Parametrised registered N-to-2^N one-hot decoder with a built-in scan sequencer.
//  - Drives 2^N board LEDs (or display digit enables) in one of two ways:
//    - static decode of the select input;
//    - autonomous scan that walks the active output up, down or back-and-forth at a prescaled rate.
//  - Replaces cascaded 2-4/3-8/4-16 combinational decoder trees at the board top level.

---
 rtl/decoder_scan_n.sv | 131 +++++++++++++
 tb/tb_decoder_scan_n.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/decoder_scan_n.sv
// Registered N-to-2^N one-hot (or one-cold) decoder with a built-in scan sequencer.
// The active output either follows sel or walks up, down or ping-pong at a prescaled rate.
module decoder_scan_n #(
    parameter int N        = 4,
    parameter bit ACT_LOW  = 1'b1,
    parameter int PRESCALE = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [1:0]      mode,
    input  logic [N-1:0]    sel,
    input  logic            load,
    output logic [2**N-1:0] y,
    output logic [N-1:0]    index,
    output logic            wrap
);

    localparam int W  = 2**N;
    localparam int PW = $clog2(PRESCALE) + 1;

    localparam logic [N-1:0]  IDX_MAX = N'(W - 1);
    localparam logic [PW-1:0] PMAX    = PW'(PRESCALE - 1);
    localparam logic [W-1:0]  Y_IDLE  = ACT_LOW ? {W{1'b1}} : {W{1'b0}};

    typedef enum logic [1:0] {
        MODE_STATIC = 2'b00,
        MODE_UP     = 2'b01,
        MODE_DOWN   = 2'b10,
        MODE_PING   = 2'b11
    } mode_e;

    logic [N-1:0]  index_q, index_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          dir_up_q, dir_up_d;
    logic          wrap_q, wrap_d;
    logic [W-1:0]  y_q, y_d;

    logic          tick;
    logic          step_up;
    logic [W-1:0]  one_hot;

    always_comb begin
        index_d  = index_q;
        presc_d  = presc_q;
        dir_up_d = dir_up_q;
        wrap_d   = 1'b0;
        tick     = 1'b0;
        step_up  = dir_up_q;

        // Directional modes pin the direction; ping-pong inherits whatever was last used.
        if (en) begin
            if (mode == MODE_UP) begin
                dir_up_d = 1'b1;
            end else if (mode == MODE_DOWN) begin
                dir_up_d = 1'b0;
            end
        end

        if (load) begin
            index_d = sel;
            presc_d = '0;
        end else if (en) begin
            if (mode == MODE_STATIC) begin
                index_d = sel;
                presc_d = '0;
            end else begin
                tick    = (presc_q == PMAX);
                presc_d = tick ? '0 : presc_q + PW'(1);
                if (tick) begin
                    case (mode)
                        MODE_UP: begin
                            index_d = index_q + N'(1);
                            wrap_d  = (index_q == IDX_MAX);
                        end
                        MODE_DOWN: begin
                            index_d = index_q - N'(1);
                            wrap_d  = (index_q == '0);
                        end
                        default: begin
                            // A load can park the index on an endpoint facing outward; bounce it back in.
                            if (index_q == IDX_MAX) begin
                                step_up = 1'b0;
                            end else if (index_q == '0) begin
                                step_up = 1'b1;
                            end
                            index_d = step_up ? index_q + N'(1) : index_q - N'(1);
                            if ((step_up && index_d == IDX_MAX) || (!step_up && index_d == '0)) begin
                                wrap_d   = 1'b1;
                                dir_up_d = !step_up;
                            end else begin
                                dir_up_d = step_up;
                            end
                        end
                    endcase
                end
            end
        end
    end

    always_comb begin
        one_hot          = '0;
        one_hot[index_q] = 1'b1;
        if (!en) begin
            y_d = Y_IDLE;
        end else begin
            y_d = ACT_LOW ? ~one_hot : one_hot;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            index_q  <= '0;
            presc_q  <= '0;
            dir_up_q <= 1'b1;
            wrap_q   <= 1'b0;
            y_q      <= Y_IDLE;
        end else begin
            index_q  <= index_d;
            presc_q  <= presc_d;
            dir_up_q <= dir_up_d;
            wrap_q   <= wrap_d;
            y_q      <= y_d;
        end
    end

    assign y     = y_q;
    assign index = index_q;
    assign wrap  = wrap_q;

endmodule

// File: tb/tb_decoder_scan_n.sv
// Directed bench for decoder_scan_n: static decode, scan up/down, ping-pong, freeze,
// load/tick collision, a 1-bit ping-pong instance and asynchronous reset.
module tb_decoder_scan_n;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [1:0]  mode;
    logic [3:0]  sel;
    logic        load;

    logic [15:0] y, y_b;
    logic [3:0]  index, index_b;
    logic        wrap, wrap_b;
    logic [1:0]  y_c;
    logic [0:0]  index_c;
    logic        wrap_c;

    int tests_run = 0;
    int fail_cnt  = 0;
    int cur;

    decoder_scan_n #(.N(4), .ACT_LOW(1'b1), .PRESCALE(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel), .load(load),
        .y(y), .index(index), .wrap(wrap)
    );

    decoder_scan_n #(.N(4), .ACT_LOW(1'b0), .PRESCALE(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel), .load(load),
        .y(y_b), .index(index_b), .wrap(wrap_b)
    );

    decoder_scan_n #(.N(1), .ACT_LOW(1'b1), .PRESCALE(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel[0:0]), .load(load),
        .y(y_c), .index(index_c), .wrap(wrap_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] cold(input int i);
        logic [15:0] one;
        one  = 16'h0001;
        cold = ~(one << i);
    endfunction

    // Three hold cycles at `cur`, then the step edge to `nxt` with the expected wrap.
    task automatic scan_step(input int nxt, input bit w);
        for (int k = 0; k < 3; k++) begin
            step();
            check("hold_idx", 32'(index), 32'(cur));
            check("hold_wrap", 32'(wrap), 32'd0);
            check("hold_y", 32'(y), 32'(cold(cur)));
        end
        step();
        check("step_idx", 32'(index), 32'(nxt));
        check("step_wrap", 32'(wrap), 32'(w));
        cur = nxt;
    endtask

    initial begin
        logic [15:0] one;
        one   = 16'h0001;
        rst_n = 1'b0;
        en    = 1'b0;
        mode  = 2'b00;
        sel   = 4'd0;
        load  = 1'b0;
        step();
        step();
        check("rst_y", 32'(y), 32'hFFFF);
        check("rst_y_b", 32'(y_b), 32'h0000);
        check("rst_idx", 32'(index), 32'd0);
        check("rst_wrap", 32'(wrap), 32'd0);
        rst_n = 1'b1;

        // Static decode, both polarities
        en   = 1'b1;
        mode = 2'b00;
        for (int s = 0; s < 16; s++) begin
            sel = 4'(s);
            step();
            step();
            check("static_idx", 32'(index), 32'(s));
            check("static_y", 32'(y), 32'(cold(s)));
            check("static_y_b", 32'(y_b), 32'(one << s));
        end
        sel = 4'd5;
        step();
        step();
        check("static_sel5", 32'(y), 32'hFFDF);

        // Scan up from 14 across the wrap
        mode = 2'b01;
        sel  = 4'd14;
        load = 1'b1;
        step();
        load = 1'b0;
        check("up_load_idx", 32'(index), 32'd14);
        cur = 14;
        scan_step(15, 1'b0);
        scan_step(0, 1'b1);
        scan_step(1, 1'b0);

        // Ping-pong from 13 reverses at 15
        mode = 2'b11;
        sel  = 4'd13;
        load = 1'b1;
        step();
        load = 1'b0;
        check("pp_load_idx", 32'(index), 32'd13);
        cur = 13;
        scan_step(14, 1'b0);
        scan_step(15, 1'b1);
        scan_step(14, 1'b0);
        scan_step(13, 1'b0);

        // Enable freeze mid-prescale
        mode = 2'b01;
        sel  = 4'd3;
        load = 1'b1;
        step();
        load = 1'b0;
        step();
        step();
        en = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            check("frz_y", 32'(y), 32'hFFFF);
            check("frz_idx", 32'(index), 32'd3);
            check("frz_wrap", 32'(wrap), 32'd0);
        end
        en = 1'b1;
        step();
        check("resume_idx", 32'(index), 32'd3);
        check("resume_y", 32'(y), 32'hFFF7);
        step();
        check("resume_step", 32'(index), 32'd4);

        // Load on the tick cycle at the top index: no step, no wrap
        sel  = 4'd15;
        load = 1'b1;
        step();
        load = 1'b0;
        check("coll_pre_idx", 32'(index), 32'd15);
        step();
        step();
        step();
        sel  = 4'd7;
        load = 1'b1;
        step();
        load = 1'b0;
        check("coll_idx", 32'(index), 32'd7);
        check("coll_wrap", 32'(wrap), 32'd0);
        cur = 7;
        scan_step(8, 1'b0);

        // Scan down through zero
        mode = 2'b10;
        sel  = 4'd1;
        load = 1'b1;
        step();
        load = 1'b0;
        cur = 1;
        scan_step(0, 1'b0);
        scan_step(15, 1'b1);
        scan_step(14, 1'b0);

        // 1-bit ping-pong at PRESCALE=1 wraps on every step
        mode = 2'b11;
        sel  = 4'd0;
        load = 1'b1;
        step();
        load = 1'b0;
        check("n1_load_idx", 32'(index_c), 32'd0);
        check("n1_load_wrap", 32'(wrap_c), 32'd0);
        step();
        check("n1_idx_a", 32'(index_c), 32'd1);
        check("n1_wrap_a", 32'(wrap_c), 32'd1);
        check("n1_y_a", 32'(y_c), 32'h2);
        step();
        check("n1_idx_b", 32'(index_c), 32'd0);
        check("n1_wrap_b", 32'(wrap_c), 32'd1);
        check("n1_y_b", 32'(y_c), 32'h1);
        step();
        check("n1_idx_c", 32'(index_c), 32'd1);
        check("n1_wrap_c", 32'(wrap_c), 32'd1);

        // Asynchronous reset between edges
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_y", 32'(y), 32'hFFFF);
        check("arst_y_b", 32'(y_b), 32'h0000);
        check("arst_idx", 32'(index), 32'd0);
        check("arst_wrap_c", 32'(wrap_c), 32'd0);
        check("arst_idx_c", 32'(index_c), 32'd0);
        #2;
        rst_n = 1'b1;
        step();

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
        $finish;
    end

endmodule
